// File: rtl/hpdl_pkg.sv
// Shared constants, write-engine states and character helpers for the HPDL1414 chain driver.
package hpdl_pkg;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h5F;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD} wr_state_t;

  function automatic logic [7:0] fold_char(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  // Digit 3 is the leftmost on the chip, so position order runs A = 3..0.
  function automatic logic [1:0] pos_to_addr(input logic [1:0] p_lo);
    return 2'd3 - p_lo;
  endfunction
endpackage

// File: rtl/hpdl_uart_rx.sv
// 2-FF synchroniser plus 8N1 receiver; start bit re-checked at half-bit to reject glitches.
module hpdl_uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t st, st_n;

  logic meta, sync, last;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shreg, shreg_n;
  logic valid_n, err_n;

  always_comb begin
    st_n    = st;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    shreg_n = shreg;
    valid_n = 1'b0;
    err_n   = 1'b0;
    unique case (st)
      RX_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (last && !sync) st_n = RX_START;
      end
      RX_START: if (cnt == HALF_LAST) begin
        cnt_n = '0;
        st_n  = sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == FULL_LAST) begin
        cnt_n   = '0;
        shreg_n = {sync, shreg[7:1]};
        bit_n   = bit_idx + 3'd1;
        if (bit_idx == 3'd7) st_n = RX_STOP;
      end
      RX_STOP: if (cnt == FULL_LAST) begin
        st_n    = RX_IDLE;
        valid_n = sync;
        err_n   = !sync;
      end
      default: st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b1;
      sync     <= 1'b1;
      last     <= 1'b1;
      st       <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      meta     <= rx;
      sync     <= meta;
      last     <= sync;
      st       <= st_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
      rx_valid <= valid_n;
      rx_err   <= err_n;
      if (valid_n) rx_data <= shreg;
    end
  end
endmodule

// File: rtl/hpdl1414_uart_chain.sv
// UART-fed shadow buffer driving a chain of HPDL1414 displays with dirty-tracked refresh.
module hpdl1414_uart_chain
  import hpdl_pkg::*;
#(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int NUM_DISP     = 4,
  parameter int WR_SETUP_CYC = 2,
  parameter int WR_PULSE_CYC = 3,
  parameter int WR_HOLD_CYC  = 2,
  parameter int SCROLL_MODE  = 1
) (
  input  logic                CLK_i,
  input  logic                RST_i,
  input  logic                UART_RX_i,
  output logic [6:0]          HPDL_D_o,
  output logic [1:0]          HPDL_A_o,
  output logic [NUM_DISP-1:0] HPDL_WR_n_o,
  output logic                BUSY_o,
  output logic                RX_ERR_o
);
  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD;
  localparam int POS = 4*NUM_DISP;
  localparam int IW  = $clog2(POS);
  localparam int CW  = $clog2(POS+1);
  localparam logic [CW-1:0] POS_C  = CW'(POS);
  localparam logic [CW-1:0] LAST_C = CW'(POS-1);
  localparam logic [7:0] S_LAST = 8'(WR_SETUP_CYC-1);
  localparam logic [7:0] P_LAST = 8'(WR_PULSE_CYC-1);
  localparam logic [7:0] H_LAST = 8'(WR_HOLD_CYC-1);

  logic [7:0] rx_data, ch;
  logic       rx_valid;

  hpdl_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(CLK_i), .rst(RST_i), .rx(UART_RX_i),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(RX_ERR_o)
  );

  logic [POS-1:0][6:0] shadow, shadow_n;
  logic [POS-1:0]      dirty, dirty_set, dirty_clr;
  logic [CW-1:0]       cursor, cursor_n;

  always_comb begin
    shadow_n  = shadow;
    cursor_n  = cursor;
    dirty_set = '0;
    ch        = fold_char(rx_data);
    if (rx_valid) begin
      if (ch >= PRINT_MIN && ch <= PRINT_MAX) begin
        if (SCROLL_MODE != 0 && cursor == POS_C) begin
          for (int i = 0; i < POS-1; i++) shadow_n[i] = shadow[i+1];
          shadow_n[POS-1] = ch[6:0];
          dirty_set       = '1;
        end else begin
          shadow_n[cursor[IW-1:0]]  = ch[6:0];
          dirty_set[cursor[IW-1:0]] = 1'b1;
          cursor_n = (SCROLL_MODE == 0 && cursor == LAST_C) ? '0 : cursor + CW'(1);
        end
      end else if (ch == CH_CR) begin
        cursor_n = '0;
      end else if (ch == CH_FF) begin
        shadow_n  = {POS{CH_SPACE[6:0]}};
        dirty_set = '1;
        cursor_n  = '0;
      end else if (ch == CH_BS && cursor != '0) begin
        cursor_n = cursor - CW'(1);
        shadow_n[cursor_n[IW-1:0]]  = CH_SPACE[6:0];
        dirty_set[cursor_n[IW-1:0]] = 1'b1;
      end
    end
  end

  wr_state_t     st, st_n;
  logic [7:0]    ph_cnt, ph_cnt_n;
  logic [IW-1:0] sel, wr_pos;
  logic          latch;

  always_comb begin
    sel = '0;
    for (int i = POS-1; i >= 0; i--) if (dirty[i]) sel = IW'(i);
  end

  always_comb begin
    st_n      = st;
    ph_cnt_n  = ph_cnt + 8'd1;
    dirty_clr = '0;
    latch     = 1'b0;
    unique case (st)
      ST_IDLE: begin
        ph_cnt_n = '0;
        if (|dirty) begin
          latch          = 1'b1;
          dirty_clr[sel] = 1'b1;
          st_n           = ST_SETUP;
        end
      end
      ST_SETUP: if (ph_cnt == S_LAST) begin st_n = ST_PULSE; ph_cnt_n = '0; end
      ST_PULSE: if (ph_cnt == P_LAST) begin st_n = ST_HOLD;  ph_cnt_n = '0; end
      ST_HOLD:  if (ph_cnt == H_LAST) st_n = ST_IDLE;
      default:  st_n = ST_IDLE;
    endcase
  end

  // A decode update that lands on the entry being latched keeps it dirty: set wins over clear.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      st       <= ST_IDLE;
      ph_cnt   <= '0;
      shadow   <= {POS{CH_SPACE[6:0]}};
      dirty    <= '1;
      cursor   <= '0;
      HPDL_D_o <= '0;
      HPDL_A_o <= '0;
      wr_pos   <= '0;
    end else begin
      st     <= st_n;
      ph_cnt <= ph_cnt_n;
      shadow <= shadow_n;
      dirty  <= (dirty & ~dirty_clr) | dirty_set;
      cursor <= cursor_n;
      if (latch) begin
        HPDL_D_o <= shadow[sel];
        HPDL_A_o <= pos_to_addr(sel[1:0]);
        wr_pos   <= sel;
      end
    end
  end

  always_comb begin
    HPDL_WR_n_o = '1;
    if (st == ST_PULSE) HPDL_WR_n_o = ~(NUM_DISP'(1) << (wr_pos >> 2));
  end

  assign BUSY_o = (|dirty) || (st != ST_IDLE);
endmodule

// File: doc/hpdl1414_uart_chain.md
Name: hpdl1414_uart_chain

Overview:
Parametrised successor to the single-display UART driver. It receives 8N1 bytes on one UART line and keeps a shadow buffer of 4*NUM_DISP characters. It drives a chain of NUM_DISP HPDL1414 displays over a shared data/address bus, with one active-low WR strobe per chip. Added over the previous generation: control characters, lowercase folding, wrap or scroll mode, and dirty-tracked refresh with programmable write timing.

Parameters:
CLK_HZ, 12000000, input clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = round(CLK_HZ/BAUD), must be >= 8
NUM_DISP, 4, number of HPDL1414 chips (1..8); POS = 4*NUM_DISP character positions
WR_SETUP_CYC, 2, cycles D/A are valid before WR falls (>= 1)
WR_PULSE_CYC, 3, cycles WR is held low (>= 1)
WR_HOLD_CYC, 2, cycles D/A are held after WR rises (>= 1)
SCROLL_MODE, 1, 0 = cursor wraps to position 0; 1 = buffer shifts left when full

Ports:
CLK_i  in  1  system clock
RST_i  in  1  asynchronous, active-high reset
UART_RX_i  in  1  serial input, idle high, asynchronous to CLK_i
HPDL_D_o  out  7  character code, shared by all chips
HPDL_A_o  out  2  digit address, shared by all chips
HPDL_WR_n_o  out  NUM_DISP  per-chip write strobe, active low
BUSY_o  out  1  high while any dirty bit is set or the write engine is not IDLE
RX_ERR_o  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset: every buffer entry = 0x20; all dirty bits = 1 so the displays blank after reset; cursor = 0; HPDL_D_o = 0; HPDL_A_o = 0; HPDL_WR_n_o = all 1s; RX_ERR_o = 0; engine in IDLE. BUSY_o is therefore 1 straight out of reset.
- Reset asserted mid-write: WR_n goes high immediately (asynchronous), and the write restarts from the blank state.
- UART RX:
  - 2-FF synchroniser on UART_RX_i.
  - A falling edge starts reception; the start bit is re-sampled at CLKS_PER_BIT/2 and a high sample there aborts as a glitch.
  - Data bits are sampled LSB first at mid-bit.
  - A stop bit sampled high raises rx_valid for 1 cycle (cycle t).
  - A stop bit sampled low discards the byte and pulses RX_ERR_o for 1 cycle.
- Byte decode, registered at t+1:
  - 0x61..0x7A are folded to byte-0x20.
  - Printable 0x20..0x5F: see the write rules below.
  - 0x0D: cursor = 0.
  - 0x0C: all entries = 0x20, all dirty, cursor = 0.
  - 0x08: if cursor > 0, cursor-- and the entry at the new cursor = 0x20 (dirty); at cursor 0, no effect.
  - All other bytes are ignored.
- Printable write, SCROLL_MODE = 0: buf[cursor] = char, dirty set, cursor = (cursor+1) mod POS.
- Printable write, SCROLL_MODE = 1: cursor ranges 0..POS.
  - cursor < POS: write at cursor, then cursor++.
  - cursor == POS: buf[i] = buf[i+1] for i < POS-1, buf[POS-1] = char, all positions dirty.
- Position mapping: position p maps to chip p/4 and HPDL_A_o = 3-(p mod 4). Position 0 is the leftmost character of chip 0.
- Write engine FSM: IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
  - IDLE: if any dirty bit is set, select the lowest-index dirty p, latch buf[p] onto D and the mapped address onto A, clear dirty[p], and enter SETUP. The earliest entry is t+2 for a byte completed at t.
  - SETUP: WR_SETUP_CYC cycles with all WR_n high.
  - PULSE: WR_PULSE_CYC cycles with WR_n[p/4] low and all others high.
  - HOLD: WR_HOLD_CYC cycles with all WR_n high and D/A unchanged.
  - One character costs S+P+H cycles of engine time; D/A stay stable between writes.
- Simultaneous events:
  - A decode update to position p in the same cycle the engine clears dirty[p]: dirty[p] stays set, because set wins.
  - A new value written to p while p is mid-write is rewritten on a later pass.
- The shadow buffer updates in one cycle, so no byte is lost while the engine is busy. The block has no flow control and never back-pressures the UART.

Decomposition:
- Package hpdl_pkg holds:
  - character constants: CH_SPACE=0x20, CH_CR=0x0D, CH_FF=0x0C, CH_BS=0x08, PRINT_MIN=0x20, PRINT_MAX=0x5F
  - the write-engine state enum
  - function fold_char (lowercase to uppercase)
  - function pos_to_addr (position to digit address)
- Sub-module hpdl_uart_rx(CLKS_PER_BIT): synchroniser plus 8N1 receiver, outputs rx_data[7:0], rx_valid and rx_err.
- Decode, shadow buffer, dirty bits and write engine stay in the top module.

Test Plan (CLK_HZ=12000000, BAUD=1000000, i.e. 12 clk/bit; NUM_DISP=2; S/P/H = 2/3/2):
- Reset, then idle line -> 8 writes of 0x20, at positions 0..7 in order. Each write has a 3-cycle WR_n low on chip 0 then chip 1 with A = 3,2,1,0. BUSY_o falls after the last HOLD.
- Send "hi" after the blanking completes -> 0x48 is written to chip 0 A=3 and 0x49 to chip 0 A=2. The first SETUP begins 2 cycles after rx_valid.
- SCROLL_MODE=1: send "ABCDEFGHI" -> the final buffer reads "BCDEFGHI". The last byte triggers a rewrite of all 8 positions, with chip 1 A=0 = 0x49.
- SCROLL_MODE=0: send 9 characters "ABCDEFGHJ" -> position 0 is overwritten with 0x4A and the cursor ends at 1.
- Send "AB", 0x08, then 0x0C -> the BS writes 0x20 at position 1. The FF leaves all positions at 0x20 and cursor 0, with 8 writes issued.
- Send a byte with its stop bit low -> RX_ERR_o pulses for exactly 1 cycle, the buffer is unchanged, and no WR_n activity occurs.
